cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0.sv | 84 ++++++++
 tb/tb_cp0.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// MIPS-style coprocessor 0 with SR, Cause, EPC and PRId, plus interrupt request logic.
// Reads are combinational from A1; every state update is registered on the rising clock edge.
module cp0 (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic [29:0] PC,
    input  logic [5:0]  HWInt,
    input  logic        wen,
    input  logic        EPCWr,
    input  logic        EXLSet,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0]  REG_SR   = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC  = 5'd14;
    localparam logic [4:0]  REG_PRID = 5'd15;
    localparam logic [31:0] PRID_VAL = 32'h0001_0001;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic [5:0]  ip;
    logic [29:0] epc;

    // The controller keeps wen high during interrupt entry, so an mtc0 only counts without EPCWr.
    logic mtc0_wr;
    assign mtc0_wr = wen & ~EPCWr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            im  <= 6'd0;
            exl <= 1'b0;
            ie  <= 1'b0;
            ip  <= 6'd0;
            epc <= 30'd0;
        end else begin
            ip <= HWInt;

            // With EXL already set, a repeated EPCWr must not overwrite the first capture.
            if (EPCWr) begin
                if (!exl) begin
                    epc <= PC;
                end
            end else if (mtc0_wr && A2 == REG_EPC) begin
                epc <= DIn[31:2];
            end

            if (mtc0_wr && A2 == REG_SR) begin
                im <= DIn[15:10];
                ie <= DIn[0];
            end

            if (EXLSet) begin
                exl <= 1'b1;
            end else if (EXLClr) begin
                exl <= 1'b0;
            end else if (mtc0_wr && A2 == REG_SR) begin
                exl <= DIn[1];
            end
        end
    end

    assign IntReq = (|(ip & im)) & ie & ~exl;
    assign EPC    = epc;

    always_comb begin
        DOut = 32'h0;
        case (A1)
            REG_SR:    DOut = {16'b0, im, 8'b0, exl, ie};
            REG_CAUSE: DOut = {16'b0, ip, 10'b0};
            REG_EPC:   DOut = {epc, 2'b00};
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: reset, interrupt enable/request, entry, eret, priority and masking.
// Expected values are queued as each step is driven and popped when the DUT output is sampled.
module tb_cp0;

    logic        clk;
    logic        rst;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic [29:0] PC;
    logic [5:0]  HWInt;
    logic        wen;
    logic        EPCWr;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    logic [31:0] exp_q[$];
    int total;
    int bad;

    cp0 dut (
        .clk    (clk),
        .rst    (rst),
        .A1     (A1),
        .A2     (A2),
        .DIn    (DIn),
        .PC     (PC),
        .HWInt  (HWInt),
        .wen    (wen),
        .EPCWr  (EPCWr),
        .EXLSet (EXLSet),
        .EXLClr (EXLClr),
        .IntReq (IntReq),
        .EPC    (EPC),
        .DOut   (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so inputs and samples sit away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, expv);
            end
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] expv);
        exp_q.push_back(expv);
        A1 = addr;
        #1;
        chk(tag, DOut);
    endtask

    task automatic irq(input string tag, input logic expv);
        exp_q.push_back({31'b0, expv});
        chk(tag, {31'b0, IntReq});
    endtask

    task automatic epc_port(input string tag, input logic [29:0] expv);
        exp_q.push_back({2'b00, expv});
        chk(tag, {2'b00, EPC});
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        wen = 1'b1;
        A2  = addr;
        DIn = data;
        tick();
        wen = 1'b0;
        DIn = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; PC = 30'h0;
        EPCWr = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;

        // Reset held while a write and all interrupt lines are active.
        rst = 1'b0; HWInt = 6'h3F; wen = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
        tick();
        tick();
        rst = 1'b1; wen = 1'b0; DIn = 32'h0;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0001_0001);
        rd("rst_unimpl", 5'd7, 32'h0);
        irq("rst_irq", 1'b0);
        HWInt = 6'h0;
        tick();

        // Enable IM[10] and IE, then raise line 0.
        mtc0(5'd12, 32'h0000_0401);
        rd("en_sr", 5'd12, 32'h0000_0401);
        irq("en_irq_idle", 1'b0);
        HWInt = 6'b000001;
        #1;
        irq("en_irq_same_cycle", 1'b0);
        tick();
        irq("en_irq_one_later", 1'b1);
        rd("en_cause", 5'd13, 32'h0000_0400);

        // Two-cycle interrupt entry; PC changes in the second cycle and must not be captured.
        PC = 30'h0000_0C05; EPCWr = 1'b1; EXLSet = 1'b1; wen = 1'b1; A2 = 5'd12; DIn = 32'h0;
        tick();
        irq("entry_irq_n1", 1'b0);
        PC = 30'h0000_1060;
        tick();
        EPCWr = 1'b0; EXLSet = 1'b0; wen = 1'b0;
        epc_port("entry_epc_port", 30'h0000_0C05);
        rd("entry_epc_rd", 5'd14, 32'h0000_3014);
        rd("entry_sr", 5'd12, 32'h0000_0403);
        irq("entry_irq", 1'b0);

        // eret with line 0 still pending re-raises the request.
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        irq("eret_irq", 1'b1);
        HWInt = 6'b000000;
        #1;
        irq("drop_irq_same", 1'b1);
        tick();
        irq("drop_irq_1", 1'b0);
        tick();
        irq("drop_irq_2", 1'b0);

        // EXLSet beats EXLClr on the same edge.
        EXLSet = 1'b1; EXLClr = 1'b1;
        tick();
        EXLSet = 1'b0; EXLClr = 1'b0;
        rd("prio_sr", 5'd12, 32'h0000_0403);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("clr_sr", 5'd12, 32'h0000_0401);

        // Writes to read-only or unimplemented numbers leave everything alone.
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        mtc0(5'd7, 32'hFFFF_FFFF);
        rd("ro_sr", 5'd12, 32'h0000_0401);
        rd("ro_cause", 5'd13, 32'h0);
        rd("ro_epc", 5'd14, 32'h0000_3014);
        rd("ro_prid", 5'd15, 32'h0001_0001);
        rd("ro_unimpl", 5'd7, 32'h0);

        // Masking: line 1 is not enabled.
        HWInt = 6'b000010;
        tick();
        rd("mask_cause", 5'd13, 32'h0000_0800);
        irq("mask_irq", 1'b0);
        HWInt = 6'b000011;
        tick();
        irq("mask_irq_line0", 1'b1);

        // mtc0 to EPC, and EXL set through SR write suppresses the request.
        mtc0(5'd14, 32'hDEAD_BEEF);
        epc_port("mtc0_epc_port", 30'h37AB_6FBB);
        rd("mtc0_epc_rd", 5'd14, 32'hDEAD_BEEC);
        mtc0(5'd12, 32'h0000_FC03);
        rd("mtc0_sr_exl", 5'd12, 32'h0000_FC03);
        irq("mtc0_exl_irq", 1'b0);

        // Reset in the middle of an entry sequence wins over every strobe.
        mtc0(5'd12, 32'h0000_0401);
        PC = 30'h0000_0123; EPCWr = 1'b1; EXLSet = 1'b1; wen = 1'b1; A2 = 5'd12;
        DIn = 32'hFFFF_FFFF; rst = 1'b0;
        tick();
        rst = 1'b1; EPCWr = 1'b0; EXLSet = 1'b0; wen = 1'b0; DIn = 32'h0; HWInt = 6'h0;
        rd("midrst_sr", 5'd12, 32'h0);
        rd("midrst_epc", 5'd14, 32'h0);
        rd("midrst_cause", 5'd13, 32'h0);
        irq("midrst_irq", 1'b0);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
